acc_task_launcher: RTL and testbench

Consumer stage directly downstream of the accelerator ready queue. It pops one full task slot (tid, twid, NARGS arguments, 64-bit words) from the queue read port and presents it to the accelerator through a valid/ready start handshake. It then waits for the accelerator's done pulse and writes a two-word finish message (tid, twid) to the finish queue write port. Exactly one task is in flight at a time.

---
 rtl/acc_df_pkg.sv | 25 ++
 rtl/acc_task_launcher.sv | 143 ++++++++++++++
 tb/tb_acc_task_launcher.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_df_pkg.sv
// Shared dataflow definitions for the ready queue and the task launcher:
// data width, task slot geometry and the launcher state encoding.
package acc_df_pkg;

    localparam int DATA_W    = 64;
    localparam int TID_OFS   = 0;
    localparam int TWID_OFS  = 1;
    localparam int ARG_OFS   = 2;
    localparam int MAX_NARGS = 14;

    // A slot is tid, twid, then the argument words.
    function automatic int slot_size(input int nargs);
        return nargs + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAUNCH,
        ST_RUN,
        ST_REPORT_TID,
        ST_REPORT_TWID
    } launch_state_t;

endpackage

// File: rtl/acc_task_launcher.sv
// Pops one task slot from the ready queue, launches it on the accelerator (valid/ready),
// waits for done and reports tid/twid to the finish queue; stalls on start_ready and fq_full.
module acc_task_launcher
    import acc_df_pkg::*;
#(
    parameter int NARGS = 1,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rq_empty,
    output logic                    rq_read,
    input  logic [DATA_W-1:0]       rq_dout,
    output logic                    acc_start_valid,
    input  logic                    acc_start_ready,
    output logic [DATA_W-1:0]       acc_tid,
    output logic [DATA_W-1:0]       acc_twid,
    output logic [NARGS*DATA_W-1:0] acc_args,
    input  logic                    acc_done,
    input  logic                    fq_full,
    output logic                    fq_write,
    output logic [DATA_W-1:0]       fq_din,
    output logic [CNT_W-1:0]        task_count
);

    localparam int SLOT  = slot_size(NARGS);
    localparam int IDX_W = $clog2(SLOT) + 1;

    launch_state_t           r_state;
    launch_state_t           w_next;
    logic                    r_run;
    logic [IDX_W-1:0]        r_rd_cnt;
    logic                    r_cap_vld;
    logic [IDX_W-1:0]        r_cap_idx;
    logic [DATA_W-1:0]       r_tid;
    logic [DATA_W-1:0]       r_twid;
    logic [NARGS*DATA_W-1:0] r_args;
    logic [CNT_W-1:0]        r_task_count;

    logic                    w_rq_read;
    logic [IDX_W-1:0]        w_rd_idx;
    logic                    w_start_vld;
    logic                    w_fq_write;
    logic [DATA_W-1:0]       w_fq_din;

    always_comb begin
        w_next      = r_state;
        w_rq_read   = 1'b0;
        w_rd_idx    = r_rd_cnt;
        w_start_vld = 1'b0;
        w_fq_write  = 1'b0;
        w_fq_din    = '0;
        case (r_state)
            ST_IDLE: begin
                w_rd_idx = '0;
                if (r_run && !rq_empty) begin
                    w_rq_read = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // rq_empty is deliberately ignored: a partly drained slot reads as empty.
                w_rq_read = (r_rd_cnt < IDX_W'(SLOT));
                if (r_cap_vld && (r_cap_idx == IDX_W'(SLOT - 1)))
                    w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_start_vld = 1'b1;
                if (acc_start_ready)
                    w_next = ST_RUN;
            end
            ST_RUN: begin
                if (acc_done)
                    w_next = ST_REPORT_TID;
            end
            ST_REPORT_TID: begin
                if (!fq_full) begin
                    w_fq_write = 1'b1;
                    w_fq_din   = r_tid;
                    w_next     = ST_REPORT_TWID;
                end
            end
            ST_REPORT_TWID: begin
                if (!fq_full) begin
                    w_fq_write = 1'b1;
                    w_fq_din   = r_twid;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read data arrives one cycle after the read, so the word index is delayed with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run        <= 1'b0;
            r_rd_cnt     <= '0;
            r_cap_vld    <= 1'b0;
            r_cap_idx    <= '0;
            r_tid        <= '0;
            r_twid       <= '0;
            r_args       <= '0;
            r_task_count <= '0;
        end else begin
            r_run     <= 1'b1;
            r_cap_vld <= w_rq_read;
            r_cap_idx <= w_rd_idx;
            if (w_rq_read)
                r_rd_cnt <= w_rd_idx + IDX_W'(1);
            if (r_cap_vld) begin
                if (r_cap_idx == IDX_W'(TID_OFS))
                    r_tid <= rq_dout;
                if (r_cap_idx == IDX_W'(TWID_OFS))
                    r_twid <= rq_dout;
                for (int i = 0; i < NARGS; i++) begin
                    if (r_cap_idx == IDX_W'(ARG_OFS + i))
                        r_args[DATA_W*i +: DATA_W] <= rq_dout;
                end
            end
            if (r_state == ST_REPORT_TWID && w_fq_write)
                r_task_count <= r_task_count + CNT_W'(1);
        end
    end

    assign rq_read         = w_rq_read;
    assign acc_start_valid = w_start_vld;
    assign acc_tid         = r_tid;
    assign acc_twid        = r_twid;
    assign acc_args        = r_args;
    assign fq_write        = w_fq_write;
    assign fq_din          = w_fq_din;
    assign task_count      = r_task_count;

endmodule

// File: tb/tb_acc_task_launcher.sv
// Scoreboard bench for acc_task_launcher with NARGS=2 and a behavioural ready queue.
module tb_acc_task_launcher;

    localparam int NARGS = 2;
    localparam int SLOT  = NARGS + 2;

    typedef struct {
        logic [63:0]  tid;
        logic [63:0]  twid;
        logic [127:0] args;
    } start_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rq_empty;
    logic         rq_read;
    logic [63:0]  rq_dout = '0;
    logic         acc_start_valid;
    logic         acc_start_ready = 1'b0;
    logic [63:0]  acc_tid;
    logic [63:0]  acc_twid;
    logic [127:0] acc_args;
    logic         acc_done = 1'b0;
    logic         fq_full = 1'b0;
    logic         fq_write;
    logic [63:0]  fq_din;
    logic [31:0]  task_count;

    acc_task_launcher #(.NARGS(NARGS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rq_empty(rq_empty), .rq_read(rq_read), .rq_dout(rq_dout),
        .acc_start_valid(acc_start_valid), .acc_start_ready(acc_start_ready),
        .acc_tid(acc_tid), .acc_twid(acc_twid), .acc_args(acc_args),
        .acc_done(acc_done),
        .fq_full(fq_full), .fq_write(fq_write), .fq_din(fq_din),
        .task_count(task_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ready queue model: registered read data, empty until a full slot is present.
    logic [63:0] rq_q[$];
    logic        rd_pend = 1'b0;
    assign rq_empty = (rq_q.size() < SLOT);

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_pend) begin
            if (rq_q.size() == 0) check("rq_underflow", 1, 0);
            else rq_dout = rq_q.pop_front();
        end
    end

    // Scoreboard queues and monitor state.
    start_t      exp_start[$];
    logic [63:0] exp_fq[$];
    int cyc = 0, rd_total = 0, rd_rise = 0, vld_rise = 0, vld_cnt = 0;
    int acc_cnt = 0, fq_cnt = 0, fq_last = 0, fq_prev = 0;
    logic prev_rd = 1'b0, prev_vld = 1'b0, hold_prev = 1'b0;
    logic [63:0]  sv_tid, sv_twid;
    logic [127:0] sv_args;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rd_pend = rq_read && rst;
        if (rq_read) rd_total++;
        if (rq_read && !prev_rd) rd_rise = cyc;
        prev_rd = rq_read;
        if (rq_read && (acc_start_valid || fq_write)) check("rd_outside_fetch", rq_read, 0);

        if (fq_write) begin
            check("fq_write_while_full", fq_full, 0);
            fq_cnt++;
            fq_prev = fq_last;
            fq_last = cyc;
            if (exp_fq.size() == 0) check("fq_unexpected_write", fq_din, 128'hDEAD);
            else check("fq_din", fq_din, exp_fq.pop_front());
        end else if (fq_din !== 64'h0) begin
            check("fq_din_idle_zero", fq_din, 0);
        end

        if (acc_start_valid && !prev_vld) begin
            vld_rise = cyc;
            vld_cnt++;
        end
        if (hold_prev) begin
            check("valid_held", acc_start_valid, 1);
            check("tid_stable", acc_tid, sv_tid);
            check("twid_stable", acc_twid, sv_twid);
            check("args_stable", acc_args, sv_args);
        end
        hold_prev = acc_start_valid && !acc_start_ready;
        sv_tid  = acc_tid;
        sv_twid = acc_twid;
        sv_args = acc_args;
        if (acc_start_valid && acc_start_ready) begin
            acc_cnt++;
            if (exp_start.size() == 0) check("start_unexpected", acc_tid, 128'hDEAD);
            else begin
                start_t e;
                e = exp_start.pop_front();
                check("acc_tid", acc_tid, e.tid);
                check("acc_twid", acc_twid, e.twid);
                check("acc_args", acc_args, e.args);
            end
        end
        prev_vld = acc_start_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_slot(input logic [63:0] tid, input logic [63:0] twid,
                             input logic [63:0] a0, input logic [63:0] a1);
        start_t e;
        e.tid  = tid;
        e.twid = twid;
        e.args = {a1, a0};
        exp_start.push_back(e);
        rq_q.push_back(tid);
        rq_q.push_back(twid);
        rq_q.push_back(a0);
        rq_q.push_back(a1);
    endtask

    task automatic expect_finish(input logic [63:0] tid, input logic [63:0] twid);
        exp_fq.push_back(tid);
        exp_fq.push_back(twid);
    endtask

    task automatic pulse_done();
        acc_done = 1'b1;
        tick(1);
        acc_done = 1'b0;
    endtask

    task automatic wait_accept(input int target);
        int t = 0;
        while (acc_cnt < target && t < 200) begin
            tick(1);
            t++;
        end
        check("accept_count", acc_cnt, target);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!acc_start_valid && t < 200) begin
            tick(1);
            t++;
        end
        check("valid_seen", acc_start_valid, 1);
    endtask

    task automatic wait_fq(input int target);
        int t = 0;
        while (fq_cnt < target && t < 200) begin
            tick(1);
            t++;
        end
        check("fq_count", fq_cnt, target);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        rq_q.delete();
        exp_start.delete();
    endtask

    initial begin
        int twid_cyc, vr;

        // Reset held with a slot waiting.
        load_slot(64'h11, 64'h22, 64'hA, 64'hB);
        acc_start_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rq_read", rq_read, 0);
        check("rst_valid", acc_start_valid, 0);
        check("rst_fq_write", fq_write, 0);
        check("rst_task_count", task_count, 0);
        check("rst_acc_tid", acc_tid, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rd_release_cycle", rq_read, 0);
        @(negedge clk);
        check("rd_cycle_after_release", rq_read, 1);

        // Single task.
        wait_accept(1);
        check("t0_to_valid", vld_rise - rd_rise, SLOT + 1);
        check("reads_slot1", rd_total, 4);
        tick(9);
        expect_finish(64'h11, 64'h22);
        pulse_done();
        wait_fq(2);
        check("fq_consecutive_1", fq_last - fq_prev, 1);
        check("task_count_1", task_count, 1);

        // Start and finish backpressure.
        acc_start_ready = 1'b0;
        load_slot(64'h33, 64'h44, 64'h1, 64'h2);
        wait_valid();
        tick(3);
        acc_start_ready = 1'b1;
        wait_accept(2);
        fq_full = 1'b1;
        expect_finish(64'h33, 64'h44);
        pulse_done();
        tick(4);
        check("no_write_while_full", fq_cnt, 2);
        fq_full = 1'b0;
        wait_fq(4);
        check("fq_consecutive_2", fq_last - fq_prev, 1);
        check("task_count_2", task_count, 2);

        // Back-to-back slots.
        load_slot(64'h55, 64'h66, 64'h3, 64'h4);
        load_slot(64'h77, 64'h88, 64'h5, 64'h6);
        wait_accept(3);
        expect_finish(64'h55, 64'h66);
        pulse_done();
        wait_fq(6);
        twid_cyc = fq_last;
        wait_accept(4);
        check("refetch_gap", rd_rise - twid_cyc, 1);
        check("reads_b2b", rd_total, 16);
        expect_finish(64'h77, 64'h88);
        pulse_done();
        wait_fq(8);
        check("task_count_b2b", task_count, 4);

        // Spurious done in IDLE, FETCH and on the accept cycle.
        acc_start_ready = 1'b0;
        pulse_done();
        load_slot(64'h99, 64'hAA, 64'h7, 64'h8);
        tick(2);
        pulse_done();
        wait_valid();
        acc_start_ready = 1'b1;
        acc_done = 1'b1;
        tick(1);
        acc_start_ready = 1'b0;
        acc_done = 1'b0;
        tick(10);
        check("spurious_no_fq", fq_cnt, 8);
        check("spurious_accepted", acc_cnt, 5);
        expect_finish(64'h99, 64'hAA);
        pulse_done();
        wait_fq(10);
        check("task_count_spur", task_count, 5);

        // Reset during RUN.
        acc_start_ready = 1'b1;
        load_slot(64'hBB, 64'hCC, 64'h9, 64'hA);
        wait_accept(6);
        tick(2);
        do_reset();
        @(negedge clk);
        check("rst_run_valid", acc_start_valid, 0);
        check("rst_run_count", task_count, 0);
        tick(20);
        check("rst_run_no_fq", fq_cnt, 10);

        // Reset during FETCH.
        load_slot(64'hDD, 64'hEE, 64'h1, 64'h1);
        tick(2);
        do_reset();
        vr = vld_cnt;
        tick(20);
        check("rst_fetch_no_launch", vld_cnt, vr);
        check("rst_fetch_count", task_count, 0);
        check("rst_fetch_no_fq", fq_cnt, 10);

        // Recovery after reset.
        load_slot(64'hF1, 64'hF2, 64'h3, 64'h4);
        wait_accept(7);
        expect_finish(64'hF1, 64'hF2);
        pulse_done();
        wait_fq(12);
        check("task_count_recover", task_count, 1);
        check("exp_fq_drained", exp_fq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
